ascon_block_feeder: RTL and testbench
=====================================

Name: ascon_block_feeder

Overview:
- Upstream stage of the data organizer.
- Accepts a 64-bit word stream (associated data or plaintext) with a valid/ready handshake.
- Groups the words into rate-sized blocks (64 or 128 bits) and applies Ascon 10* padding.
- Presents each block right-aligned on bloc_o, with a block index, for the organizer to mask and shift into the state.

Parameters:
- nb_bits_data, 128, width of bloc_o; must be ≥ 128.

Ports:
- clock_i  in  1  system clock, rising edge
- resetb_i  in  1  asynchronous reset, active low
- start_i  in  1  one-cycle pulse; begins a new message (sampled in IDLE only)
- size_treated_data_r_i  in  8  rate r in bits, latched on start_i; 128 gives 2 words/block, any other value is treated as 64 (1 word/block)
- data_i  in  64  input word; byte 0 is data_i[63:56]
- data_bytes_i  in  4  valid bytes in data_i; 8 on non-last words, 0..8 on the last word (0 = empty final word)
- data_last_i  in  1  marks the final word of the message
- data_valid_i  in  1  word valid
- data_ready_o  out  1  word accepted when data_valid_i && data_ready_o
- bloc_o  out  nb_bits_data  padded block; r bits in [r-1:0], upper bits zero
- bloc_s_o  out  4  block index within the message, saturating at 15
- bloc_last_o  out  1  this block is the final (padded) block
- bloc_valid_o  out  1  block valid
- bloc_ready_i  in  1  block consumed when bloc_valid_o && bloc_ready_i
- done_o  out  1  one-cycle pulse after the final block is consumed

Behaviour:
- Reset values:
  - State is IDLE.
  - All outputs are 0: data_ready_o, bloc_valid_o, bloc_last_o, done_o, bloc_o, bloc_s_o.
  - Internal word counter, byte offset and rate register are cleared.
- Reset mid-message aborts immediately. No partial block is ever emitted afterwards.
- States:
  - IDLE:
    - On start_i: latch rate (words_per_block = 2 if r == 128, else 1), clear bloc_s, go to FILL.
    - start_i outside IDLE is ignored.
  - FILL:
    - data_ready_o = 1.
    - Each accepted word is written at the current byte offset of the block buffer; byte 0 of the block is bloc_o[r-1:r-8].
    - Non-last word: when the block is complete, go to EMIT; otherwise advance the offset by 8.
    - Last word with n bytes:
      - Write n bytes, then 0x80 at offset+n, zeros above it.
      - If offset+n == r/8, no pad byte fits: go to EMIT with need_pad = 1.
      - Otherwise mark final and go to EMIT.
  - EMIT:
    - data_ready_o = 0; bloc_valid_o = 1; bloc_o, bloc_s_o and bloc_last_o are held stable until bloc_ready_i.
    - On handshake:
      - final: go to IDLE and pulse done_o the next cycle.
      - need_pad: go to PAD.
      - otherwise: bloc_s += 1 (saturating), clear the buffer, go to FILL.
  - PAD:
    - Emit block 0x80 followed by zeros: bloc_o[r-1:r-8] = 8'h80, rest 0.
    - bloc_last_o = 1; bloc_s is incremented first.
    - On handshake: go to IDLE and pulse done_o.
- Latency: bloc_valid_o rises the cycle after the word completing the block is accepted. Throughput is 1 word/cycle in FILL; at most one block is outstanding.
- data_ready_o and bloc_valid_o are never both 1.
- Boundary cases:
  - Empty message (first word last, n = 0): one block 0x80 00…, index 0, last.
  - r = 128 and the last word fills the first half with n = 8: the pad goes into the second half; no extra block.
  - data_bytes_i > 8: treated as 8.
  - data_bytes_i < 8 on a non-last word: treated as 8 (undefined input; not checked).
- Bytes beyond n in data_i are masked to zero regardless of their value.

Test Plan:
- r=64, start, words 0x0011223344556677 and 0x8899AABBCCDDEEFF (8 bytes, last) -> three blocks:
  - 0x0011223344556677, idx 0
  - 0x8899AABBCCDDEEFF, idx 1
  - pad 0x8000000000000000, idx 2, last
  - done_o pulses once.
- r=128, one last word 0xDEADBEEF_xxxxxxxx with 4 bytes -> bloc_o[127:0] = 0xDEADBEEF800000000000000000000000, idx 0, last.
- r=128, last word 8 bytes 0x0102030405060708 in the first half -> 0x0102030405060708_8000000000000000, single block, last, no PAD.
- Empty message (r=64, data_bytes_i=0, last) -> 0x8000000000000000, idx 0, last.
- Backpressure: hold bloc_ready_i=0 for 5 cycles -> bloc_o stable, data_ready_o=0 throughout; release -> next FILL begins the following cycle.
- Assert resetb_i low during EMIT -> all outputs 0 immediately; after release, no block is emitted until a new start_i.

Source files
------------

// File: rtl/ascon_block_feeder.sv
// Groups a 64-bit word stream into Ascon rate blocks (64 or 128 bits), applies 10* padding
// and presents each block right-aligned with its index under a valid/ready handshake.
module ascon_block_feeder #(
  parameter int unsigned nb_bits_data = 128
) (
  input  logic                    clock_i,
  input  logic                    resetb_i,
  input  logic                    start_i,
  input  logic [7:0]              size_treated_data_r_i,
  input  logic [63:0]             data_i,
  input  logic [3:0]              data_bytes_i,
  input  logic                    data_last_i,
  input  logic                    data_valid_i,
  output logic                    data_ready_o,
  output logic [nb_bits_data-1:0] bloc_o,
  output logic [3:0]              bloc_s_o,
  output logic                    bloc_last_o,
  output logic                    bloc_valid_o,
  input  logic                    bloc_ready_i,
  output logic                    done_o
);

  typedef enum logic [1:0] {StIdle, StFill, StEmit, StPad} state_t;

  state_t                  state;
  logic                    rate128;
  logic                    final_blk;
  logic                    need_pad;
  logic [3:0]              offset;
  logic                    accept;
  logic                    fill_done;
  logic [3:0]              n_eff;
  logic [63:0]             word;
  logic [nb_bits_data-1:0] pad_blk;

  always_comb begin
    accept    = data_valid_i && data_ready_o;
    fill_done = !rate128 || (offset == 4'd8);
    if (!data_last_i || (data_bytes_i > 4'd8)) n_eff = 4'd8;
    else                                        n_eff = data_bytes_i;
    // Keep the first n bytes, drop 0x80 right after them on a short last word.
    word = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < n_eff)       word[63-8*i -: 8] = data_i[63-8*i -: 8];
      else if (4'(i) == n_eff) word[63-8*i -: 8] = 8'h80;
    end
    pad_blk = '0;
    if (rate128) pad_blk[127:120] = 8'h80;
    else         pad_blk[63:56]   = 8'h80;
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state        <= StIdle;
      rate128      <= 1'b0;
      final_blk    <= 1'b0;
      need_pad     <= 1'b0;
      offset       <= 4'd0;
      data_ready_o <= 1'b0;
      bloc_o       <= '0;
      bloc_s_o     <= 4'd0;
      bloc_last_o  <= 1'b0;
      bloc_valid_o <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start_i) begin
            rate128      <= (size_treated_data_r_i == 8'd128);
            bloc_s_o     <= 4'd0;
            offset       <= 4'd0;
            bloc_o       <= '0;
            final_blk    <= 1'b0;
            need_pad     <= 1'b0;
            data_ready_o <= 1'b1;
            state        <= StFill;
          end
        end
        StFill: begin
          if (accept) begin
            if (rate128 && (offset == 4'd0)) bloc_o[127:64] <= word;
            else                             bloc_o[63:0]   <= word;
            if (data_last_i) begin
              data_ready_o <= 1'b0;
              bloc_valid_o <= 1'b1;
              state        <= StEmit;
              if ((n_eff == 4'd8) && fill_done) begin
                need_pad <= 1'b1;
              end else begin
                final_blk   <= 1'b1;
                bloc_last_o <= 1'b1;
                // Full last word in the first half of a 128-bit block: pad lands in the second.
                if (n_eff == 4'd8) bloc_o[63:0] <= {8'h80, 56'h0};
              end
            end else if (fill_done) begin
              data_ready_o <= 1'b0;
              bloc_valid_o <= 1'b1;
              state        <= StEmit;
            end else begin
              offset <= 4'd8;
            end
          end
        end
        StEmit: begin
          if (bloc_ready_i) begin
            if (final_blk) begin
              bloc_valid_o <= 1'b0;
              bloc_last_o  <= 1'b0;
              final_blk    <= 1'b0;
              bloc_o       <= '0;
              done_o       <= 1'b1;
              state        <= StIdle;
            end else begin
              if (bloc_s_o != 4'hf) bloc_s_o <= bloc_s_o + 4'd1;
              if (need_pad) begin
                need_pad    <= 1'b0;
                bloc_o      <= pad_blk;
                bloc_last_o <= 1'b1;
                state       <= StPad;
              end else begin
                bloc_o       <= '0;
                offset       <= 4'd0;
                bloc_valid_o <= 1'b0;
                data_ready_o <= 1'b1;
                state        <= StFill;
              end
            end
          end
        end
        StPad: begin
          if (bloc_ready_i) begin
            bloc_valid_o <= 1'b0;
            bloc_last_o  <= 1'b0;
            bloc_o       <= '0;
            done_o       <= 1'b1;
            state        <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_block_feeder.sv
// Directed bench for ascon_block_feeder: padding cases, block indices, backpressure, reset abort.
module tb_ascon_block_feeder;

  logic         clock_i = 1'b0;
  logic         resetb_i;
  logic         start_i;
  logic [7:0]   size_treated_data_r_i;
  logic [63:0]  data_i;
  logic [3:0]   data_bytes_i;
  logic         data_last_i;
  logic         data_valid_i;
  logic         data_ready_o;
  logic [127:0] bloc_o;
  logic [3:0]   bloc_s_o;
  logic         bloc_last_o;
  logic         bloc_valid_o;
  logic         bloc_ready_i;
  logic         done_o;

  int checks   = 0;
  int failures = 0;

  ascon_block_feeder #(.nb_bits_data(128)) dut (
    .clock_i               (clock_i),
    .resetb_i              (resetb_i),
    .start_i               (start_i),
    .size_treated_data_r_i (size_treated_data_r_i),
    .data_i                (data_i),
    .data_bytes_i          (data_bytes_i),
    .data_last_i           (data_last_i),
    .data_valid_i          (data_valid_i),
    .data_ready_o          (data_ready_o),
    .bloc_o                (bloc_o),
    .bloc_s_o              (bloc_s_o),
    .bloc_last_o           (bloc_last_o),
    .bloc_valid_o          (bloc_valid_o),
    .bloc_ready_i          (bloc_ready_i),
    .done_o                (done_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, {127'b0, data_ready_o}, 128'd0);
    check({tag, "_valid"}, {127'b0, bloc_valid_o}, 128'd0);
    check({tag, "_last"},  {127'b0, bloc_last_o},  128'd0);
    check({tag, "_done"},  {127'b0, done_o},       128'd0);
    check({tag, "_bloc"},  bloc_o,                 128'd0);
    check({tag, "_idx"},   {124'b0, bloc_s_o},     128'd0);
  endtask

  task automatic start_msg(input logic [7:0] r);
    @(negedge clock_i);
    start_i = 1'b1;
    size_treated_data_r_i = r;
    @(negedge clock_i);
    start_i = 1'b0;
  endtask

  // Called on a falling edge; returns on the falling edge after the word is accepted.
  task automatic send_word(input logic [63:0] d, input logic [3:0] n, input logic last);
    int cnt = 0;
    data_i = d;
    data_bytes_i = n;
    data_last_i = last;
    data_valid_i = 1'b1;
    while (!data_ready_o && cnt < 50) begin
      @(negedge clock_i);
      cnt++;
    end
    if (cnt >= 50) check("send_timeout", {127'b0, data_ready_o}, 128'd1);
    @(negedge clock_i);
    data_valid_i = 1'b0;
    data_last_i = 1'b0;
  endtask

  task automatic expect_block(input string tag, input logic [127:0] exp_b,
                              input logic [3:0] exp_s, input logic exp_last);
    int cnt = 0;
    while (!bloc_valid_o && cnt < 50) begin
      @(negedge clock_i);
      cnt++;
    end
    check({tag, "_valid"}, {127'b0, bloc_valid_o}, 128'd1);
    check({tag, "_bloc"},  bloc_o, exp_b);
    check({tag, "_idx"},   {124'b0, bloc_s_o}, {124'b0, exp_s});
    check({tag, "_last"},  {127'b0, bloc_last_o}, {127'b0, exp_last});
    check({tag, "_noready"}, {127'b0, data_ready_o}, 128'd0);
    bloc_ready_i = 1'b1;
    @(negedge clock_i);
    bloc_ready_i = 1'b0;
    check({tag, "_done"}, {127'b0, done_o}, {127'b0, exp_last});
    if (exp_last) begin
      @(negedge clock_i);
      check({tag, "_done_pulse"}, {127'b0, done_o}, 128'd0);
    end
  endtask

  initial begin
    resetb_i = 1'b0;
    start_i = 1'b0;
    size_treated_data_r_i = 8'd0;
    data_i = '0;
    data_bytes_i = '0;
    data_last_i = 1'b0;
    data_valid_i = 1'b0;
    bloc_ready_i = 1'b0;
    #1;
    check_idle_outputs("reset");
    repeat (2) @(negedge clock_i);
    resetb_i = 1'b1;

    // r=64, two full words: the second is last and full, so a separate pad block follows.
    start_msg(8'd64);
    send_word(64'h0011223344556677, 4'd8, 1'b0);
    expect_block("r64_b0", 128'h0011223344556677, 4'd0, 1'b0);
    send_word(64'h8899AABBCCDDEEFF, 4'd8, 1'b1);
    expect_block("r64_b1", 128'h8899AABBCCDDEEFF, 4'd1, 1'b0);
    expect_block("r64_pad", 128'h8000000000000000, 4'd2, 1'b1);

    // r=128, short last word; junk bytes beyond n must be masked.
    start_msg(8'd128);
    send_word(64'hDEADBEEF12345678, 4'd4, 1'b1);
    expect_block("r128_short", 128'hDEADBEEF800000000000000000000000, 4'd0, 1'b1);

    // r=128, full last word in the first half: pad goes in the second half.
    start_msg(8'd128);
    send_word(64'h0102030405060708, 4'd8, 1'b1);
    expect_block("r128_half", 128'h0102030405060708_8000000000000000, 4'd0, 1'b1);
    check("r128_half_no_pad", {127'b0, bloc_valid_o}, 128'd0);

    // Empty message.
    start_msg(8'd64);
    send_word(64'hFFFFFFFFFFFFFFFF, 4'd0, 1'b1);
    expect_block("empty", 128'h8000000000000000, 4'd0, 1'b1);

    // r=128, two words, last with byte count 15 (treated as 8) fills the block -> pad block.
    start_msg(8'd128);
    send_word(64'h1111111111111111, 4'd8, 1'b0);
    send_word(64'h2222222222222222, 4'd15, 1'b1);
    expect_block("over8_b0", 128'h1111111111111111_2222222222222222, 4'd0, 1'b0);
    expect_block("over8_pad", 128'h80000000000000000000000000000000, 4'd1, 1'b1);

    // Backpressure: block held stable, no word accepted, FILL resumes right after release.
    start_msg(8'd64);
    send_word(64'hA5A5A5A55A5A5A5A, 4'd8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_bloc", bloc_o, 128'hA5A5A5A55A5A5A5A);
      check("bp_valid", {127'b0, bloc_valid_o}, 128'd1);
      check("bp_ready", {127'b0, data_ready_o}, 128'd0);
      @(negedge clock_i);
    end
    expect_block("bp_b0", 128'hA5A5A5A55A5A5A5A, 4'd0, 1'b0);
    check("bp_refill", {127'b0, data_ready_o}, 128'd1);
    send_word(64'hCAFEBABE00000000, 4'd3, 1'b1);
    expect_block("bp_b1", 128'hCAFEBA8000000000, 4'd1, 1'b1);

    // Reset while a block is outstanding.
    start_msg(8'd64);
    send_word(64'h0123456789ABCDEF, 4'd8, 1'b0);
    check("rst_pre_valid", {127'b0, bloc_valid_o}, 128'd1);
    resetb_i = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    @(negedge clock_i);
    resetb_i = 1'b1;
    data_i = 64'h1122334455667788;
    data_bytes_i = 4'd8;
    data_last_i = 1'b1;
    data_valid_i = 1'b1;
    bloc_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock_i);
      check("rst_post_valid", {127'b0, bloc_valid_o}, 128'd0);
      check("rst_post_ready", {127'b0, data_ready_o}, 128'd0);
    end
    data_valid_i = 1'b0;
    data_last_i = 1'b0;
    bloc_ready_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
